pwl_act_stream: RTL

PWL_ACT_STREAM -- requirements
Module: pwl_act_stream

---
 rtl/pwl_act_pkg.sv | 32 +++
 rtl/pwl_seg_select.sv | 24 ++
 rtl/pwl_act_stream.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pwl_act_pkg.sv
// pwl_act_pkg: shared definitions for the piecewise-linear activation stream.
//   cfg_sel_e        - table select encodings for the configuration port
//   DEF_*_H          - reset-default table constants, in units of 0.5 (2^(FRAC_W-1))
//   pwl_sat()        - clamp a wide signed value to a signed w-bit range
package pwl_act_pkg;

  typedef enum logic [1:0] {
    CFG_BP    = 2'd0,
    CFG_SLOPE = 2'd1,
    CFG_ICPT  = 2'd2,
    CFG_NONE  = 2'd3
  } cfg_sel_e;

  // Hard-tanh defaults expressed in half-units so they scale with FRAC_W.
  localparam int DEF_BP_LO_H  = -1;  // bp[0]         = -0.5
  localparam int DEF_BP_HI_H  = 1;   // bp[1..]       = +0.5
  localparam int DEF_M_RAMP_H = 4;   // m[1]          = 2.0
  localparam int DEF_C_LO_H   = -2;  // c[0]          = -1.0
  localparam int DEF_C_HI_H   = 2;   // c[2..]        = +1.0

  function automatic logic signed [63:0] pwl_sat(input logic signed [63:0] v,
                                                 input int unsigned      w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pwl_seg_select.sv
// pwl_seg_select: segment index for a sample, the number of breakpoints
// the sample is greater than or equal to (signed compare).
//   i_x   - signed sample
//   i_bp  - breakpoint table, NUM_SEG-1 signed entries
//   o_seg - segment index 0..NUM_SEG-1
module pwl_seg_select #(
  parameter int DATA_W  = 16,
  parameter int NUM_SEG = 8
) (
  input  logic [DATA_W-1:0]                i_x,
  input  logic [NUM_SEG-2:0][DATA_W-1:0]   i_bp,
  output logic [$clog2(NUM_SEG)-1:0]       o_seg
);

  localparam int SEG_W = $clog2(NUM_SEG);

  always_comb begin
    o_seg = '0;
    for (int unsigned i = 0; i < NUM_SEG - 1; i++) begin
      if ($signed(i_x) >= $signed(i_bp[i])) o_seg = o_seg + SEG_W'(1);
    end
  end

endmodule

// File: rtl/pwl_act_stream.sv
// pwl_act_stream: streaming piecewise-linear activation,
//   y = sat(((m[s]*x + 2^(FRAC_W-1)) >>> FRAC_W) + c[s])
// Three pipeline stages (select/capture, multiply, round/add/saturate), all
// advancing together whenever the output register can take new data.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   in_data/in_valid/in_ready       - sample input stream
//   out_data/out_valid/out_ready    - result output stream
//   cfg_we/cfg_sel/cfg_addr/cfg_data- table write port (sel 0=bp,1=m,2=c,3=none)
//   sat_clr/sat_cnt                 - saturation counter, only with PWL_SAT_CNT_EN
// Optional feature macro: PWL_SAT_CNT_EN
module pwl_act_stream
  import pwl_act_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 12,
  parameter int NUM_SEG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data
`ifdef PWL_SAT_CNT_EN
  ,
  input  logic              sat_clr,
  output logic [15:0]       sat_cnt
`endif
);

  localparam int SEG_W  = $clog2(NUM_SEG);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 1;
  localparam int HALF   = 1 << (FRAC_W - 1);

  localparam logic [DATA_W-1:0] BP_LO  = DATA_W'(DEF_BP_LO_H * HALF);
  localparam logic [DATA_W-1:0] BP_HI  = DATA_W'(DEF_BP_HI_H * HALF);
  localparam logic [DATA_W-1:0] M_RAMP = DATA_W'(DEF_M_RAMP_H * HALF);
  localparam logic [DATA_W-1:0] C_LO   = DATA_W'(DEF_C_LO_H * HALF);
  localparam logic [DATA_W-1:0] C_HI   = DATA_W'(DEF_C_HI_H * HALF);
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(HALF);

  logic [NUM_SEG-2:0][DATA_W-1:0] r_bp;
  logic [NUM_SEG-1:0][DATA_W-1:0] r_m;
  logic [NUM_SEG-1:0][DATA_W-1:0] r_c;

  logic [31:0]       w_addr;
  logic              w_adv;
  logic [SEG_W-1:0]  w_seg;

  logic                     r_v1;
  logic signed [DATA_W-1:0] r_x1;
  logic signed [DATA_W-1:0] r_m1;
  logic signed [DATA_W-1:0] r_c1;
  logic                     r_v2;
  logic signed [PROD_W-1:0] r_prod2;
  logic signed [DATA_W-1:0] r_c2;
  logic                     r_ov;
  logic [DATA_W-1:0]        r_out;

  logic signed [SUM_W-1:0]  w_pext;
  logic signed [SUM_W-1:0]  w_rnd;
  logic signed [SUM_W-1:0]  w_shr;
  logic signed [SUM_W-1:0]  w_cext;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [63:0]       w_sum64;
  logic [DATA_W-1:0]        w_sat;

  assign w_addr    = {28'd0, cfg_addr};
  assign w_adv     = !r_ov || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_ov;
  assign out_data  = r_out;

  // Coefficient tables; a write lands at the edge, so a sample accepted in
  // the same cycle still sees the old contents through the S1 capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SEG - 1; i++)
        r_bp[i] <= (i == 0) ? BP_LO : BP_HI;
      for (int unsigned i = 0; i < NUM_SEG; i++) begin
        r_m[i] <= (i == 1) ? M_RAMP : '0;
        r_c[i] <= (i == 0) ? C_LO : ((i == 1) ? '0 : C_HI);
      end
    end else if (cfg_we) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_BP:
          for (int unsigned i = 0; i < NUM_SEG - 1; i++)
            if (w_addr == i) r_bp[i] <= cfg_data;
        CFG_SLOPE:
          for (int unsigned i = 0; i < NUM_SEG; i++)
            if (w_addr == i) r_m[i] <= cfg_data;
        CFG_ICPT:
          for (int unsigned i = 0; i < NUM_SEG; i++)
            if (w_addr == i) r_c[i] <= cfg_data;
        default: ;
      endcase
    end
  end

  pwl_seg_select #(
    .DATA_W  (DATA_W),
    .NUM_SEG (NUM_SEG)
  ) u_seg (
    .i_x   (in_data),
    .i_bp  (r_bp),
    .o_seg (w_seg)
  );

  // S3 arithmetic kept in separate signed wires so the shift stays arithmetic.
  assign w_pext  = {r_prod2[PROD_W-1], r_prod2};
  assign w_rnd   = w_pext + RND;
  assign w_shr   = w_rnd >>> FRAC_W;
  assign w_cext  = {{(SUM_W - DATA_W){r_c2[DATA_W-1]}}, r_c2};
  assign w_sum   = w_shr + w_cext;
  assign w_sum64 = {{(64 - SUM_W){w_sum[SUM_W-1]}}, w_sum};
  assign w_sat   = DATA_W'(pwl_sat(w_sum64, DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_x1    <= '0;
      r_m1    <= '0;
      r_c1    <= '0;
      r_v2    <= 1'b0;
      r_prod2 <= '0;
      r_c2    <= '0;
      r_ov    <= 1'b0;
      r_out   <= '0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_x1 <= in_data;
        r_m1 <= r_m[w_seg];
        r_c1 <= r_c[w_seg];
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod2 <= r_x1 * r_m1;
        r_c2    <= r_c1;
      end
      r_ov <= r_v2;
      if (r_v2) r_out <= w_sat;
    end
  end

`ifdef PWL_SAT_CNT_EN
  logic        w_clip;
  logic        r_clip3;
  logic [15:0] r_sat_cnt;

  assign w_clip  = (w_sum64 != pwl_sat(w_sum64, DATA_W));
  assign sat_cnt = r_sat_cnt;

  // Clip flag travels with the output register so only real handshakes count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clip3   <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      if (w_adv && r_v2) r_clip3 <= w_clip;
      if (sat_clr)
        r_sat_cnt <= '0;
      else if (r_ov && out_ready && r_clip3 && (r_sat_cnt != '1))
        r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end
`endif

endmodule
